conv_host: RTL
==============

CONV_HOST -- requirements
Module: conv_host

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  DATAW, 20, data width
  ADDRW, 12, address width
  RDY_TIMEOUT, 16, cycles READY may wait for busy before erroring
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  clock
  reset  in  1  reset; synchronous, active-low
  start  in  1  pulse; begin one accelerator run
  img_we  in  1  image preload write enable
  img_addr  in  ADDRW  image preload address
  img_data  in  DATAW  image preload data
  ready  out  1  run request to accelerator
  busy  in  1  accelerator busy
  iaddr  in  ADDRW  image read address
  idata  out  DATAW  image read data
  csel  in  3  bank select
  cwr  in  1  bank write strobe
  caddr_wr  in  ADDRW  bank write address
  cdata_wr  in  DATAW  bank write data
  crd  in  1  bank read strobe
  caddr_rd  in  ADDRW  bank read address
  cdata_rd  out  DATAW  bank read data
  dbg_sel  in  3  dump bank select
  dbg_addr  in  ADDRW  dump address
  dbg_data  out  DATAW  dump data
  done  out  1  one-cycle pulse at end of run
  err  out  1  sticky protocol error

Function
REQ-003 Storage SHALL be: image 4096 words; bank 001 and 010, 4096 words each; bank 011 and 100, 1024 words each; bank 101, 2048 words.
REQ-004 img_we SHALL write img_data to image[img_addr] at posedge, in IDLE only; img_we outside IDLE SHALL be ignored and SHALL set err.
REQ-005 idata SHALL equal image[iaddr] sampled at the previous posedge (1-cycle latency), in every state.
REQ-006 cwr=1 SHALL write cdata_wr to bank csel at caddr_wr at posedge.
REQ-007 A write with csel of 000 or 11x, or caddr_wr at or above the bank depth, SHALL be dropped and SHALL set err.
REQ-008 crd=1 SHALL load cdata_rd with bank csel at caddr_rd, valid the next cycle; cdata_rd SHALL hold when crd=0.
REQ-009 A read from an invalid csel or an out-of-range address SHALL return 0.
REQ-010 When cwr and crd hit the same bank and address in one cycle, cdata_rd SHALL return the old data (read-before-write).
REQ-011 dbg_data SHALL equal bank dbg_sel at dbg_addr, registered, 1-cycle latency; dbg_sel 000 SHALL select the image.
REQ-012 FSM states SHALL be IDLE, READY, RUN, FIN.
REQ-013 IDLE -> READY on start.
REQ-014 READY: ready=1; -> RUN on busy=1; -> IDLE with err set after RDY_TIMEOUT cycles without busy.
REQ-015 RUN: ready=0; -> FIN on busy falling 1->0.
REQ-016 FIN: done=1 for exactly one cycle; -> IDLE.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 busy=1 in IDLE SHALL set err.
REQ-019 ready SHALL be registered and SHALL deassert in the cycle after busy is sampled high.
REQ-020 Storage SHALL have no reset and SHALL persist across runs.

Reset
REQ-021 reset=0 at posedge SHALL force IDLE, and ready=0, done=0, err=0, idata=0, cdata_rd=0, dbg_data=0, timeout counter=0.
REQ-022 reset mid-run SHALL abort to IDLE without a done pulse; writes in the reset cycle SHALL be dropped.

Configuration
REQ-023 With CONV_HOST_WCNT_EN defined: per-bank 13-bit saturating write counters SHALL count accepted writes, SHALL clear on entering READY, and SHALL be readable on dbg_data when dbg_sel=110 and dbg_addr[2:0] is the bank number. Without it: no counters, and dbg_sel 11x SHALL return 0.

Verification
REQ-024 Preload image[0x041]=0x00123, then iaddr=0x041 -> idata=0x00123 one cycle later.
REQ-025 start, busy rises 3 cycles later, falls 100 cycles later -> ready high for 3 cycles; done pulses 1 cycle after the fall; err=0.
REQ-026 start, busy held 0 -> READY lasts 16 cycles, then IDLE with err=1 and no done.
REQ-027 cwr csel=011 caddr_wr=0x400 -> write dropped, err=1; cwr csel=101 addr=0x7FF data=0xABCDE -> dbg_sel=101, dbg_addr=0x7FF reads 0xABCDE.
REQ-028 Same-cycle cwr/crd on bank 001 addr 5 (old 0x11, new 0x22) -> cdata_rd=0x11; next read returns 0x22.
REQ-029 reset=0 during RUN -> IDLE, ready=0, done=0; bank contents preserved.

Source files
------------

// File: rtl/conv_host.sv
// ----------------------------------------------------------------------------
// conv_host
//
// Host-side glue for a convolution accelerator. It holds the image
// buffer and five coefficient/result banks. It runs the ready/busy
// handshake that starts one accelerator run, and it exposes a registered
// debug dump port.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   start                 pulse: request one accelerator run
//   img_we/addr/data      image preload write port (accepted in IDLE only)
//   ready  (out)          registered run request to the accelerator
//   busy                  accelerator busy
//   iaddr / idata (out)   image read port for the accelerator, 1-cycle latency
//   csel                  bank select (001..101 valid)
//   cwr/caddr_wr/cdata_wr bank write port
//   crd/caddr_rd          bank read strobe and address
//   cdata_rd (out)        bank read data, loaded on crd, held otherwise
//   dbg_sel/dbg_addr      dump select (000 = image) and address
//   dbg_data (out)        dump data, 1-cycle latency
//   done   (out)          one-cycle pulse at the end of a run
//   err    (out)          sticky protocol error, cleared only by reset
//
// Storage: image 4096, banks 1/2 4096, banks 3/4 1024, bank 5 2048 words.
// The storage has no reset. ADDRW must be at least 12.
//
// Build option: define CONV_HOST_WCNT_EN to add 13-bit saturating
// per-bank write counters. They clear on entry to READY and read back on
// dbg_sel=110 with dbg_addr[2:0] as the bank number. Without the option,
// dbg_sel 11x reads 0.
// ----------------------------------------------------------------------------
module conv_host #(
    parameter int DATAW       = 20,
    parameter int ADDRW       = 12,
    parameter int RDY_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             img_we,
    input  logic [ADDRW-1:0] img_addr,
    input  logic [DATAW-1:0] img_data,
    output logic             ready,
    input  logic             busy,
    input  logic [ADDRW-1:0] iaddr,
    output logic [DATAW-1:0] idata,
    input  logic [2:0]       csel,
    input  logic             cwr,
    input  logic [ADDRW-1:0] caddr_wr,
    input  logic [DATAW-1:0] cdata_wr,
    input  logic             crd,
    input  logic [ADDRW-1:0] caddr_rd,
    output logic [DATAW-1:0] cdata_rd,
    input  logic [2:0]       dbg_sel,
    input  logic [ADDRW-1:0] dbg_addr,
    output logic [DATAW-1:0] dbg_data,
    output logic             done,
    output logic             err
);

    localparam int TW = $clog2(RDY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RDY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_RUN   = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // Word count of each bank; 0 marks an unused select code.
    function automatic logic [31:0] bank_depth(input logic [2:0] sel);
        case (sel)
            3'b001, 3'b010: return 32'd4096;
            3'b011, 3'b100: return 32'd1024;
            3'b101:         return 32'd2048;
            default:        return 32'd0;
        endcase
    endfunction

    function automatic logic addr_ok(input logic [2:0] sel, input logic [ADDRW-1:0] addr);
        return 32'(addr) < bank_depth(sel);
    endfunction

    // Storage (no reset, contents persist across runs)
    logic [DATAW-1:0] img_mem   [0:4095];
    logic [DATAW-1:0] bank1_mem [0:4095];
    logic [DATAW-1:0] bank2_mem [0:4095];
    logic [DATAW-1:0] bank3_mem [0:1023];
    logic [DATAW-1:0] bank4_mem [0:1023];
    logic [DATAW-1:0] bank5_mem [0:2047];

    state_t           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             ready_q, done_q, err_q, err_d;
    logic [DATAW-1:0] idata_q, cdata_q, dbg_q;
    logic [DATAW-1:0] crd_val, dbg_val;
    logic             img_wr_en, bank_wr_ok, bank_wr_en;
    logic             timeout_err;

    // Writes are blocked in the reset cycle. Image preload is allowed
    // only while idle so the accelerator never sees the image change
    // during a run.
    assign img_wr_en  = img_we && reset && (state_q == S_IDLE);
    assign bank_wr_ok = addr_ok(csel, caddr_wr);
    assign bank_wr_en = cwr && reset && bank_wr_ok;

    always_ff @(posedge clk) begin
        if (img_wr_en) begin
            img_mem[img_addr[11:0]] <= img_data;
        end
    end

    always_ff @(posedge clk) begin
        if (bank_wr_en) begin
            case (csel)
                3'b001:  bank1_mem[caddr_wr[11:0]] <= cdata_wr;
                3'b010:  bank2_mem[caddr_wr[11:0]] <= cdata_wr;
                3'b011:  bank3_mem[caddr_wr[9:0]]  <= cdata_wr;
                3'b100:  bank4_mem[caddr_wr[9:0]]  <= cdata_wr;
                3'b101:  bank5_mem[caddr_wr[10:0]] <= cdata_wr;
                default: ;
            endcase
        end
    end

`ifdef CONV_HOST_WCNT_EN
    logic [12:0] wcnt_q [1:5];
    logic        enter_ready;

    assign enter_ready = (state_q != S_READY) && (state_d == S_READY);

    // Clearing on READY entry takes priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        for (int b = 1; b <= 5; b++) begin
            if (!reset || enter_ready) begin
                wcnt_q[b] <= '0;
            end else if (bank_wr_en && (csel == 3'(b)) && (wcnt_q[b] != 13'h1FFF)) begin
                wcnt_q[b] <= wcnt_q[b] + 13'd1;
            end
        end
    end
`endif

    // Bank read mux. Invalid selects and out-of-range addresses read 0.
    always_comb begin
        crd_val = '0;
        if (addr_ok(csel, caddr_rd)) begin
            case (csel)
                3'b001:  crd_val = bank1_mem[caddr_rd[11:0]];
                3'b010:  crd_val = bank2_mem[caddr_rd[11:0]];
                3'b011:  crd_val = bank3_mem[caddr_rd[9:0]];
                3'b100:  crd_val = bank4_mem[caddr_rd[9:0]];
                3'b101:  crd_val = bank5_mem[caddr_rd[10:0]];
                default: crd_val = '0;
            endcase
        end
    end

    // Dump mux: 000 selects the image, 001..101 select the banks.
    always_comb begin
        dbg_val = '0;
        case (dbg_sel)
            3'b000: dbg_val = img_mem[dbg_addr[11:0]];
            3'b001: if (addr_ok(dbg_sel, dbg_addr)) dbg_val = bank1_mem[dbg_addr[11:0]];
            3'b010: if (addr_ok(dbg_sel, dbg_addr)) dbg_val = bank2_mem[dbg_addr[11:0]];
            3'b011: if (addr_ok(dbg_sel, dbg_addr)) dbg_val = bank3_mem[dbg_addr[9:0]];
            3'b100: if (addr_ok(dbg_sel, dbg_addr)) dbg_val = bank4_mem[dbg_addr[9:0]];
            3'b101: if (addr_ok(dbg_sel, dbg_addr)) dbg_val = bank5_mem[dbg_addr[10:0]];
`ifdef CONV_HOST_WCNT_EN
            3'b110: begin
                case (dbg_addr[2:0])
                    3'd1:    dbg_val = DATAW'(wcnt_q[1]);
                    3'd2:    dbg_val = DATAW'(wcnt_q[2]);
                    3'd3:    dbg_val = DATAW'(wcnt_q[3]);
                    3'd4:    dbg_val = DATAW'(wcnt_q[4]);
                    3'd5:    dbg_val = DATAW'(wcnt_q[5]);
                    default: dbg_val = '0;
                endcase
            end
`endif
            default: dbg_val = '0;
        endcase
    end

    // Run handshake: IDLE -> READY (wait for busy, bounded) -> RUN (wait
    // for busy to drop) -> FIN (done pulse) -> IDLE. RUN is entered only
    // with busy high, so busy low in RUN is the falling edge.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        timeout_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READY;
                    tmo_d   = '0;
                end
            end
            S_READY: begin
                if (busy) begin
                    state_d = S_RUN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = S_IDLE;
                    timeout_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RUN: begin
                if (!busy) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (img_we && (state_q != S_IDLE)) err_d = 1'b1;
        if (cwr && !bank_wr_ok)            err_d = 1'b1;
        if (busy && (state_q == S_IDLE))   err_d = 1'b1;
        if (timeout_err)                   err_d = 1'b1;
    end

    // ready/done are decoded from the next state so they change in the
    // same edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            ready_q <= (state_d == S_READY);
            done_q  <= (state_d == S_FIN);
            err_q   <= err_d;
        end
    end

    // Registered read ports; all read before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idata_q <= '0;
            cdata_q <= '0;
            dbg_q   <= '0;
        end else begin
            idata_q <= img_mem[iaddr[11:0]];
            if (crd) begin
                cdata_q <= crd_val;
            end
            dbg_q <= dbg_val;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign err      = err_q;
    assign idata    = idata_q;
    assign cdata_rd = cdata_q;
    assign dbg_data = dbg_q;

endmodule
